// File: rtl/decoder.sv
// 3-to-8 one-hot decoder with a combinational output, a registered copy and a code-change pulse.
// Optional DECODER_ONEHOT_CHECK_EN adds a sticky err flag and a one-hot assertion on d.
module decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] d,
    output logic [7:0] d_q,
    output logic [2:0] code_q,
    output logic       chg
`ifdef DECODER_ONEHOT_CHECK_EN
    ,
    output logic       err
`endif
);

    logic [2:0] code;
    logic [7:0] d_q_d;
    logic [2:0] code_q_d;
    logic       chg_q;
    logic       chg_d;

    assign code = {a, b, c};

    always_comb begin
        d       = 8'h00;
        d[code] = 1'b1;
    end

    always_comb begin
        d_q_d    = d;
        code_q_d = code;
        chg_d    = (code != code_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q    <= 8'h00;
            code_q <= 3'b000;
            chg_q  <= 1'b0;
        end else begin
            d_q    <= d_q_d;
            code_q <= code_q_d;
            chg_q  <= chg_d;
        end
    end

    assign chg = chg_q;

`ifdef DECODER_ONEHOT_CHECK_EN
    // d_q == 0 is the legal "no selection yet" value, so only multi-hot raises err
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q | ((d_q & (d_q - 8'd1)) != 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    always_comb begin
        if (!$isunknown(code)) begin
            assert ($onehot(d));
        end
    end
`endif

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed plan steps followed by randomized cycles
// compared against a behavioural model of the decode and registered path.
module tb_decoder;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       c;
    logic [7:0] d;
    logic [7:0] d_q;
    logic [2:0] code_q;
    logic       chg;
`ifdef DECODER_ONEHOT_CHECK_EN
    logic       err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit clk_run     = 0;

    // Reference state of the registered path
    logic [7:0] m_d_q;
    logic [2:0] m_code;
    logic       m_chg;

    decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .d_q   (d_q),
        .code_q(code_q),
        .chg   (chg)
`ifdef DECODER_ONEHOT_CHECK_EN
        ,
        .err   (err)
`endif
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] onehot_of(input int n);
        return 8'(2 ** n);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_code(input int n);
        a = n[2];
        b = n[1];
        c = n[0];
    endtask

    task automatic tick();
        int n;
        n = 4 * int'(a) + 2 * int'(b) + int'(c);
        @(posedge clk);
        if (!rst_n) begin
            m_d_q  = 8'h00;
            m_code = 3'd0;
            m_chg  = 1'b0;
        end else begin
            m_chg  = (n != int'(m_code));
            m_code = 3'(n);
            m_d_q  = onehot_of(n);
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = 4 * int'(a) + 2 * int'(b) + int'(c);
        check({tag, ".d"},      d,              onehot_of(n));
        check({tag, ".d_q"},    d_q,            m_d_q);
        check({tag, ".code_q"}, {5'd0, code_q}, {5'd0, m_code});
        check({tag, ".chg"},    {7'd0, chg},    {7'd0, m_chg});
`ifdef DECODER_ONEHOT_CHECK_EN
        check({tag, ".err"},    {7'd0, err},    8'h00);
`endif
    endtask

    initial begin
        int prev;
        int n;
        rst_n = 1'b0;
        set_code(0);

        // Combinational sweep with no clock running
        for (int i = 0; i < 8; i++) begin
            set_code(i);
            #1;
            check("sweep.d", d, onehot_of(i));
            if (d === onehot_of(i)) $display("PASS sweep code=%0d d=%b", i, d);
        end
        set_code(5);
        #1;
        check("sweep.101", d, 8'b0010_0000);

        // Reset held for two edges with inputs 111
        clk_run = 1'b1;
        set_code(7);
        tick();
        tick();
        check_all("reset");
        check("reset.d_const", d, 8'b1000_0000);
        check("reset.dq_const", d_q, 8'h00);

        // Release with 011 held
        set_code(3);
        rst_n = 1'b1;
        tick();
        check_all("rel.e1");
        check("rel.e1.dq_const", d_q, 8'b0000_1000);
        check("rel.e1.chg_const", {7'd0, chg}, 8'd1);
        tick();
        check_all("rel.e2");
        check("rel.e2.chg_const", {7'd0, chg}, 8'd0);

        // 011 -> 110 between edges
        set_code(6);
        #1;
        check("chg6.d_now", d, 8'b0100_0000);
        check("chg6.dq_held", d_q, 8'b0000_1000);
        tick();
        check_all("chg6.e1");
        check("chg6.chg_const", {7'd0, chg}, 8'd1);
        tick();
        check_all("chg6.e2");

        // Reset mid-run with inputs 101
        set_code(5);
        tick();
        check_all("pre_rst");
        rst_n = 1'b0;
        tick();
        check_all("mid_rst");
        check("mid_rst.d_const", d, 8'b0010_0000);
        check("mid_rst.dq_const", d_q, 8'h00);
        rst_n = 1'b1;

        // Release straight into code 000: no change pulse expected
        set_code(0);
        tick();
        check_all("rel000");

        // Input changing every cycle keeps chg high
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            prev = (prev + 1 + int'($urandom_range(0, 6))) % 8;
            set_code(prev);
            tick();
            check_all("toggle");
            check("toggle.chg_hi", {7'd0, chg}, 8'd1);
        end

        // Randomized cycles with occasional reset
        for (int i = 0; i < 300; i++) begin
            n = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) n = int'(m_code);
            set_code(n);
            rst_n = ($urandom_range(0, 15) != 0);
            #1;
            check("rand.d_comb", d, onehot_of(n));
            tick();
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
